// File: rtl/mux_np_pipe.sv
// mux_np_pipe: N-input, W-bit registered multiplexer with a latched channel
// select and a valid/ready output stage backed by a one-entry skid buffer.
// Optional feature macro: MUX_NP_PARITY_EN adds z_par, the even parity of z,
// which is computed at capture and carried with each beat.
module mux_np_pipe #(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 2,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    sysclk,
  input  logic                    sys_rst,
  input  logic [NUM_IN*WIDTH-1:0] d_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_load,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        sel_cur,
`ifdef MUX_NP_PARITY_EN
  output logic                    z_par,
`endif
  output logic                    sel_err
);

  localparam int            NUM_SLOTS = 2 ** SEL_W;
  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W + 1)'(NUM_IN);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [SEL_W-1:0] sel_q_reg;
  logic             sel_err_reg;
  logic [WIDTH-1:0] or_data_reg;
  logic [WIDTH-1:0] sk_data_reg;

  logic [WIDTH-1:0] chan [NUM_SLOTS];
  logic             sel_valid;
  logic             load_ok;
  logic [SEL_W-1:0] eff_sel;
  logic [WIDTH-1:0] cap_data;
  logic             accept;
  logic             or_load;
  logic             sk_load;
  logic             sk_move;

  // Split the flat input bus into channels; unused select codes read as zero
  // so every select value addresses a defined slot.
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_chan
      if (gi < NUM_IN) begin : g_real
        assign chan[gi] = d_in[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign chan[gi] = '0;
      end
    end
  endgenerate

  // A valid same-cycle load bypasses the select register; an invalid one
  // falls back to the currently held select.
  assign sel_valid = ({1'b0, sel} < NUM_IN_L);
  assign load_ok   = sel_load & sel_valid;
  assign eff_sel   = load_ok ? sel : sel_q_reg;
  assign cap_data  = chan[eff_sel];
  assign accept    = in_valid & in_ready_reg;

  // Next-state and datapath steering for the output/skid storage.
  always_comb begin
    state_next = state_reg;
    or_load    = 1'b0;
    sk_load    = 1'b0;
    sk_move    = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          or_load    = 1'b1;
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && out_ready) begin
          or_load = 1'b1;
        end else if (accept) begin
          sk_load    = 1'b1;
          state_next = ST_FULL;
        end else if (out_ready) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          sk_move    = 1'b1;
          state_next = ST_ONE;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // State register; handshake flags are registered from the next state so
  // in_ready never depends combinationally on out_ready.
  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next != ST_FULL);
      out_valid_reg <= (state_next != ST_EMPTY);
    end
  end

  // Output and skid data registers; the skid drains into the output on release.
  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      or_data_reg <= '0;
      sk_data_reg <= '0;
    end else begin
      if (or_load) begin
        or_data_reg <= cap_data;
      end else if (sk_move) begin
        or_data_reg <= sk_data_reg;
      end
      if (sk_load) begin
        sk_data_reg <= cap_data;
      end
    end
  end

  // Select register and one-cycle error pulse for out-of-range loads.
  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      sel_q_reg   <= '0;
      sel_err_reg <= 1'b0;
    end else begin
      if (load_ok) begin
        sel_q_reg <= sel;
      end
      sel_err_reg <= sel_load & ~sel_valid;
    end
  end

`ifdef MUX_NP_PARITY_EN
  logic cap_par;
  logic or_par_reg;
  logic sk_par_reg;

  assign cap_par = ^cap_data;

  // Parity travels with its beat through the same output/skid path.
  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      or_par_reg <= 1'b0;
      sk_par_reg <= 1'b0;
    end else begin
      if (or_load) begin
        or_par_reg <= cap_par;
      end else if (sk_move) begin
        or_par_reg <= sk_par_reg;
      end
      if (sk_load) begin
        sk_par_reg <= cap_par;
      end
    end
  end

  assign z_par = or_par_reg;
`endif

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign z         = or_data_reg;
  assign sel_cur   = sel_q_reg;
  assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_mux_np_pipe.sv
// Testbench for mux_np_pipe: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the buffered stream.
// Honours MUX_NP_PARITY_EN when the design is built with it.
module tb_mux_np_pipe;

  logic sysclk = 1'b0;
  logic sys_rst;

  // Four-channel instance
  logic [15:0] d_in;
  logic [1:0]  sel;
  logic        sel_load, in_valid, out_ready;
  logic        in_ready, out_valid, sel_err;
  logic [3:0]  z;
  logic [1:0]  sel_cur;
`ifdef MUX_NP_PARITY_EN
  logic        z_par;
`endif

  // Three-channel instance (exercises out-of-range select codes)
  logic [11:0] d_in3;
  logic [1:0]  sel3;
  logic        sel_load3, in_valid3, out_ready3;
  logic        in_ready3, out_valid3, sel_err3;
  logic [3:0]  z3;
  logic [1:0]  sel_cur3;
`ifdef MUX_NP_PARITY_EN
  logic        z_par3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the four-channel instance
  logic [3:0] mq[$];
  int         m_selq;
  bit         m_in_ready;
  bit         m_err;

  always #5 sysclk = ~sysclk;

  mux_np_pipe #(.WIDTH(4), .NUM_IN(4)) u_dut4 (
    .sysclk(sysclk), .sys_rst(sys_rst), .d_in(d_in), .sel(sel),
    .sel_load(sel_load), .in_valid(in_valid), .in_ready(in_ready),
    .z(z), .out_valid(out_valid), .out_ready(out_ready), .sel_cur(sel_cur),
`ifdef MUX_NP_PARITY_EN
    .z_par(z_par),
`endif
    .sel_err(sel_err)
  );

  mux_np_pipe #(.WIDTH(4), .NUM_IN(3)) u_dut3 (
    .sysclk(sysclk), .sys_rst(sys_rst), .d_in(d_in3), .sel(sel3),
    .sel_load(sel_load3), .in_valid(in_valid3), .in_ready(in_ready3),
    .z(z3), .out_valid(out_valid3), .out_ready(out_ready3), .sel_cur(sel_cur3),
`ifdef MUX_NP_PARITY_EN
    .z_par(z_par3),
`endif
    .sel_err(sel_err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model step at a rising edge: the stream is a FIFO of at most two beats;
  // the head drains on out_ready, a new beat joins when the block was ready.
  task automatic model_update();
    int  eff;
    bit  acc;
    bit  sel_ok;
    if (sys_rst) begin
      mq.delete();
      m_selq     = 0;
      m_err      = 1'b0;
      m_in_ready = 1'b1;
    end else begin
      sel_ok = sel_load && (int'(sel) < 4);
      eff    = sel_ok ? int'(sel) : m_selq;
      acc    = in_valid && m_in_ready;
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (acc) mq.push_back(4'((d_in >> (eff * 4)) & 16'hF));
      if (sel_ok) m_selq = int'(sel);
      m_err      = sel_load && !(int'(sel) < 4);
      m_in_ready = (mq.size() < 2);
    end
  endtask

  task automatic model_check();
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
    chk("sel_cur", {30'd0, sel_cur}, m_selq);
    chk("sel_err", {31'd0, sel_err}, {31'd0, m_err});
    if (mq.size() > 0) begin
      chk("z", {28'd0, z}, {28'd0, mq[0]});
`ifdef MUX_NP_PARITY_EN
      chk("z_par", {31'd0, z_par}, {31'd0, ^mq[0]});
`endif
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    model_update();
    #1;
    model_check();
  endtask

  initial begin
    sys_rst = 1'b1;
    d_in = '0; sel = '0; sel_load = 0; in_valid = 0; out_ready = 0;
    d_in3 = '0; sel3 = '0; sel_load3 = 0; in_valid3 = 0; out_ready3 = 0;
    m_selq = 0; m_err = 0; m_in_ready = 1;

    // Reset state
    tick(); tick();
    chk("rst_z", {28'd0, z}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_sel_cur3", {30'd0, sel_cur3}, 32'd0);
    chk("rst_sel_err3", {31'd0, sel_err3}, 32'd0);
    sys_rst = 1'b0;

    // Single beat with same-cycle select load of channel 2
    d_in = 16'hD3A5; sel = 2'd2; sel_load = 1; in_valid = 1; out_ready = 1;
    tick();
    chk("t1_z", {28'd0, z}, 32'h3);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_sel_cur", {30'd0, sel_cur}, 32'd2);
    sel_load = 0; in_valid = 0;
    tick();
    chk("t1_drain", {31'd0, out_valid}, 32'd0);

    // Stall: three beats on channel 0 with out_ready low
    out_ready = 0; sel = 2'd0; sel_load = 1; in_valid = 1; d_in = 16'h0001;
    tick();
    chk("st_z1", {28'd0, z}, 32'h1);
    sel_load = 0; d_in = 16'h0002;
    tick();
    chk("st_full_rdy", {31'd0, in_ready}, 32'd0);
    d_in = 16'h0003;
    tick();
    chk("st_hold_z", {28'd0, z}, 32'h1);
    chk("st_hold_rdy", {31'd0, in_ready}, 32'd0);
    out_ready = 1;
    tick();
    chk("st_z2", {28'd0, z}, 32'h2);
    chk("st_rdy_back", {31'd0, in_ready}, 32'd1);
    tick();
    chk("st_z3", {28'd0, z}, 32'h3);
    in_valid = 0;
    tick();
    chk("st_empty", {31'd0, out_valid}, 32'd0);

    // Streaming with alternating select loads (bypass every cycle)
    out_ready = 1; in_valid = 1; d_in = 16'h00B7;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i % 2); sel_load = 1;
      tick();
      chk("alt_z", {28'd0, z}, (i % 2) ? 32'hB : 32'h7);
    end
    sel_load = 0; in_valid = 0;
    tick();

    // Reset while FULL discards both held beats
    out_ready = 0; in_valid = 1; d_in = 16'h1234; sel = 2'd3; sel_load = 1;
    tick(); sel_load = 0; tick();
    chk("rf_full", {31'd0, in_ready}, 32'd0);
    sys_rst = 1;
    tick();
    chk("rf_valid", {31'd0, out_valid}, 32'd0);
    chk("rf_rdy", {31'd0, in_ready}, 32'd1);
    chk("rf_z", {28'd0, z}, 32'd0);
    chk("rf_sel", {30'd0, sel_cur}, 32'd0);
    sys_rst = 0; in_valid = 0; out_ready = 1;
    tick();
    chk("rf_no_old", {31'd0, out_valid}, 32'd0);

`ifdef MUX_NP_PARITY_EN
    // Parity captured with the data
    d_in = 16'h0057; sel = 2'd0; sel_load = 1; in_valid = 1; out_ready = 1;
    tick();
    chk("par_7", {31'd0, z_par}, 32'd1);
    sel = 2'd1;
    tick();
    chk("par_5", {31'd0, z_par}, 32'd0);
    sel_load = 0; in_valid = 0;
    tick();
`endif

    // Three-channel instance: out-of-range select load
    d_in3 = 12'h9C5; sel3 = 2'd3; sel_load3 = 1; in_valid3 = 1; out_ready3 = 1;
    tick();
    chk("bad_err", {31'd0, sel_err3}, 32'd1);
    chk("bad_sel_cur", {30'd0, sel_cur3}, 32'd0);
    chk("bad_z_ch0", {28'd0, z3}, 32'h5);
    chk("bad_valid", {31'd0, out_valid3}, 32'd1);
    sel_load3 = 0; in_valid3 = 0;
    tick();
    chk("bad_err_once", {31'd0, sel_err3}, 32'd0);
    sel3 = 2'd2; sel_load3 = 1;
    tick();
    chk("good_sel_cur", {30'd0, sel_cur3}, 32'd2);
    chk("good_no_err", {31'd0, sel_err3}, 32'd0);
    sel3 = 2'd3; sel_load3 = 1; in_valid3 = 1;
    tick();
    chk("bad2_err", {31'd0, sel_err3}, 32'd1);
    chk("bad2_sel_cur", {30'd0, sel_cur3}, 32'd2);
    chk("bad2_z_ch2", {28'd0, z3}, 32'h9);
    sel_load3 = 0; in_valid3 = 0;
    tick();
    chk("bad2_err_once", {31'd0, sel_err3}, 32'd0);
    chk("bad2_drain", {31'd0, out_valid3}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      sys_rst   = ($urandom_range(0, 63) == 0);
      d_in      = 16'($urandom);
      sel       = 2'($urandom);
      sel_load  = ($urandom_range(0, 3) == 0);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_np_pipe.md
# mux_np_pipe

Parametrised N-input, W-bit registered multiplexer with a latched channel select and a valid/ready output stage that includes a one-entry skid buffer. It is the pipelined generalisation of the 4-bit 2:1 operand muxes in the working-register-file datapath. It sits between register-file read ports and the ALU/bus operand latches, where a selected operand must be held stable across downstream stalls without losing throughput.

## Interface
- WIDTH, 4, data width per channel (1..32)
- NUM_IN, 2, number of input channels (2..16)
- SEL_W, derived = max(1, clog2(NUM_IN)), select width (localparam, not overridable)

- sysclk  in  1  clock, all logic rising-edge
- sys_rst  in  1  reset, synchronous, active-high
- d_in  in  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  requested channel
- sel_load  in  1  load sel into select register
- in_valid  in  1  d_in beat offered
- in_ready  out  1  block can accept a beat this cycle
- z  out  WIDTH  selected, registered data
- out_valid  out  1  z holds a valid beat
- out_ready  in  1  downstream accepts z this cycle
- sel_cur  out  SEL_W  current select register value
- sel_err  out  1  one-cycle pulse: rejected out-of-range sel_load

## Operation
- Select register sel_q: reset 0. On sel_load with sel < NUM_IN, sel_q <= sel; with sel >= NUM_IN, sel_q is unchanged and sel_err pulses high on the next cycle.
- Effective select for a beat accepted this cycle is sel when sel_load is high and sel is valid (bypass); otherwise it is sel_q.
- Accept: in_valid & in_ready. The captured value is d_in slice[effective select]. Later d_in changes do not affect a captured beat.
- Storage: output register (OR) plus skid register (SK). States:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE (beat into OR).
  - ONE: out_valid=1, in_ready=1.
    - Accept & out_ready -> ONE (new beat into OR).
    - Accept & !out_ready -> FULL (beat into SK).
    - !accept & out_ready -> EMPTY.
  - FULL: out_valid=1, in_ready=0. out_ready -> ONE (SK moves to OR).
- Ordering is strict FIFO. No beat is dropped or duplicated.
- z stays stable while out_valid & !out_ready.
- Reset values: z=0, out_valid=0, in_ready=1 after reset, sel_cur=0, sel_err=0, state EMPTY, SK=0.
- Reset mid-operation: all beats in OR and SK are discarded. Beats are not presented after reset.

## Timing
- Latency: 1 cycle, from the accept edge to out_valid/z.
- Throughput: 1 beat per cycle while out_ready stays high.
- in_ready is a registered output, derived from state only (state != FULL). It does not depend combinationally on out_ready.
- sel_cur updates on the edge after sel_load.
- sel_err is asserted for exactly the one cycle after the bad load.
- Simultaneous sel_load and accept: the accepted beat uses the new select. An invalid sel in that case falls back to sel_q.
- Simultaneous out_ready in FULL with in_valid: no accept (in_ready=0). The SK->OR move happens. in_ready=1 on the next cycle.
- sys_rst overrides every other input in the same cycle.

## Configuration
- MUX_NP_PARITY_EN defined:
  - Adds port z_par (out, 1), the even parity (XOR reduction) of z.
  - z_par is computed at capture, stored alongside the data in OR and SK, and reset to 0.
- Undefined: port z_par is absent. There is no parity logic, and all other behaviour is identical.

## Test plan
- Reset, then WIDTH=4, NUM_IN=4: d_in=16'hD3A5, sel_load with sel=2, in_valid=1 for one cycle, out_ready=1 -> next cycle z=4'h3, out_valid=1, sel_cur=2; the cycle after, out_valid=0.
- Stall: out_ready=0 with 3 beats offered back-to-back (channel 0 = 1,2,3) -> in_ready drops after beat 2 and beat 3 is held. Raise out_ready -> z sequence 1,2,3 on consecutive cycles with no loss.
- NUM_IN=3, sel_load with sel=3 -> sel_err=1 for exactly 1 cycle, sel_cur unchanged (0), and a concurrent beat uses channel 0.
- Streaming at out_ready=1, alternating sel_load 0/1 every cycle with d_in={4'hB,4'h7} -> z alternates 7,B,7,B, showing same-cycle bypass.
- Assert sys_rst while in state FULL -> next cycle out_valid=0, in_ready=1, z=0, sel_cur=0. The old beats never appear.
- With MUX_NP_PARITY_EN defined: captures z=4'h7 -> z_par=1, and z=4'h5 -> z_par=0.
